// File: rtl/alu_vector_pipe.sv
// Pipelined vector ALU: LANES independent N-bit lanes share one op, with a per-lane enable.
// Two register stages (operands, then results) with full-throughput backpressure and a sticky flag OR.
module alu_vector_pipe #(
  parameter int N     = 32,
  parameter int LANES = 8,
  parameter int V     = N * LANES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [V-1:0]       A,
  input  logic [V-1:0]       B,
  input  logic [2:0]         ALUControl,
  input  logic [LANES-1:0]   lane_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [V-1:0]       result,
  output logic [4*LANES-1:0] flags,
  output logic [3:0]         sticky_flags,
  input  logic               sticky_clr
);

  localparam int K = $clog2(N);

  logic             s1_valid;
  logic [V-1:0]     s1_a;
  logic [V-1:0]     s1_b;
  logic [2:0]       s1_op;
  logic [LANES-1:0] s1_en;

  logic                s1_adv;
  logic                s2_adv;
  logic                xfer;
  logic [V-1:0]        c_result;
  logic [4*LANES-1:0]  c_flags;
  logic [N+3:0]        lane_out;
  logic [3:0]          beat_or;

  // Handshake: a beat moves across an interface on a cycle where valid & ready are both high.
  // A stage loads when it is empty or its contents move on this cycle; ready never depends on in_valid.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign xfer     = out_valid && out_ready;

  // Returns {N,Z,C,V, result} for one lane; arithmetic carries through bit N only.
  function automatic logic [N+3:0] lane_alu(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic [2:0]   op);
    logic [N:0]   wide;
    logic [N-1:0] r;
    logic [K-1:0] amt;
    logic         c;
    logic         v;
    wide = '0;
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    amt  = b[K-1:0];
    case (op)
      3'b000: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[N-1:0];
        c    = wide[N];
        v    = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      3'b001: begin
        wide = {1'b0, a} - {1'b0, b};
        r    = wide[N-1:0];
        c    = ~wide[N];
        v    = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: begin
        // The guard bit above the lane catches the last bit shifted out.
        wide = {1'b0, a} << amt;
        r    = wide[N-1:0];
        c    = wide[N];
      end
      3'b110: begin
        wide = {a, 1'b0} >> amt;
        r    = wide[N:1];
        c    = wide[0];
      end
      default: r = b;
    endcase
    return {r[N-1], (r == '0), c, v, r};
  endfunction

  always_comb begin
    c_result = '0;
    c_flags  = '0;
    lane_out = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_out = lane_alu(s1_a[N*i +: N], s1_b[N*i +: N], s1_op);
      if (s1_en[i]) begin
        c_result[N*i +: N] = lane_out[N-1:0];
        c_flags[4*i +: 4]  = lane_out[N+3:N];
      end else begin
        c_result[N*i +: N] = s1_a[N*i +: N];
      end
    end
  end

  // Disabled lanes already carry zero flags, so a plain OR over all lanes suffices.
  always_comb begin
    beat_or = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_or = beat_or | flags[4*i +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_en    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= A;
        s1_b  <= B;
        s1_op <= ALUControl;
        s1_en <= lane_en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= c_result;
        flags  <= c_flags;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (xfer) begin
      sticky_flags <= (sticky_clr ? 4'b0000 : sticky_flags) | beat_or;
    end else if (sticky_clr) begin
      sticky_flags <= '0;
    end
  end

endmodule
